// File: rtl/blockade_pkg.sv
// Shared constants for the Blockade input block: port indices, port 0 bit layout
// and the debounced-bit ordering used between the top and its debouncers.
package blockade_pkg;

  localparam logic [1:0] PORT_IN0 = 2'd0;
  localparam logic [1:0] PORT_IN1 = 2'd1;
  localparam logic [1:0] PORT_IN2 = 2'd2;
  localparam logic [1:0] PORT_IN3 = 2'd3;

  localparam int P0_BTN_LSB   = 0;
  localparam int P0_DSW_LSB   = 4;
  localparam int P0_START_BIT = 6;
  localparam int P0_COIN_BIT  = 7;

  localparam int COIN_ACK_BIT = 0;

  // Debounced bits: [7:0] buttons, then coin, then start
  localparam int NUM_DEB   = 10;
  localparam int DEB_COIN  = 8;
  localparam int DEB_START = 9;

endpackage

// File: rtl/blockade_debounce.sv
// One-bit frame-rate debouncer: the stable value follows the raw input only after
// DEB_FRAMES consecutive frame ticks that all disagree with the current stable value.
module blockade_debounce #(
  parameter int DEB_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  logic       stable_q, stable_d;
  logic [2:0] cnt_q, cnt_d, cntInc;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= 3'd0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any agreeing sample restarts the run, so only an unbroken run of disagreement flips the bit
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    cntInc   = cnt_q + 3'd1;
    if (tick) begin
      if (raw == stable_q) begin
        cnt_d = 3'd0;
      end else if (cntInc == 3'(DEB_FRAMES)) begin
        stable_d = raw;
        cnt_d    = 3'd0;
      end else begin
        cnt_d = cntInc;
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/blockade_inputs.sv
// Player controls, coin and DIP switches for the Blockade core: frame-rate debounce,
// CPU-acknowledged coin latch, stretched coin meter and the active-low INP read mux.
module blockade_inputs
  import blockade_pkg::*;
#(
  parameter int DEB_FRAMES        = 2,
  parameter int COIN_PULSE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic [7:0] buttons,
  input  logic       coin,
  input  logic       start,
  input  logic [7:0] dsw,
  input  logic [1:0] port_sel,
  input  logic       outp_wr,
  input  logic [7:0] outp_data,
  output logic [7:0] data_out,
  output logic       coin_counter
);

  logic               vblank_q;
  logic               tick;
  logic [NUM_DEB-1:0] rawBits;
  logic [NUM_DEB-1:0] stableBits;
  logic               coinStable_q;
  logic               coinEdge;
  logic               coinAck;
  logic               coinLatch_q, coinLatch_d;
  logic [3:0]         meter_q, meter_d;
  logic               unused_outpData;

  // vblank_q resets high so a vblank already asserted at reset release is not a tick
  assign tick    = vblank & ~vblank_q;
  assign rawBits = {start, coin, buttons};

  for (genvar i = 0; i < NUM_DEB; i++) begin : gDeb
    blockade_debounce #(
      .DEB_FRAMES(DEB_FRAMES)
    ) uDeb (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .raw   (rawBits[i]),
      .stable(stableBits[i])
    );
  end

  assign coinEdge        = stableBits[DEB_COIN] & ~coinStable_q;
  assign coinAck         = outp_wr && (port_sel == PORT_IN1) && outp_data[COIN_ACK_BIT];
  assign unused_outpData = ^outp_data[7:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q     <= 1'b1;
      coinStable_q <= 1'b0;
      coinLatch_q  <= 1'b0;
      meter_q      <= 4'd0;
    end else begin
      vblank_q     <= vblank;
      coinStable_q <= stableBits[DEB_COIN];
      coinLatch_q  <= coinLatch_d;
      meter_q      <= meter_d;
    end
  end

  // A fresh coin beats a simultaneous acknowledge, and reloads rather than extends the meter
  always_comb begin
    coinLatch_d = coinLatch_q;
    if (coinEdge) begin
      coinLatch_d = 1'b1;
    end else if (coinAck) begin
      coinLatch_d = 1'b0;
    end

    meter_d = meter_q;
    if (coinEdge) begin
      meter_d = 4'(COIN_PULSE_FRAMES);
    end else if (tick && (meter_q != 4'd0)) begin
      meter_d = meter_q - 4'd1;
    end
  end

  assign coin_counter = (meter_q != 4'd0);

  always_comb begin
    data_out = 8'hFF;
    case (port_sel)
      PORT_IN0: begin
        data_out[P0_COIN_BIT]                = ~coinLatch_q;
        data_out[P0_START_BIT]               = ~stableBits[DEB_START];
        data_out[P0_DSW_LSB +: 2]            = dsw[1:0];
        data_out[P0_BTN_LSB +: 4]            = ~stableBits[3:0];
      end
      PORT_IN1: data_out = {4'hF, ~stableBits[7:4]};
      PORT_IN2: data_out = dsw;
      PORT_IN3: data_out = 8'hFF;
      default:  data_out = 8'hFF;
    endcase
  end

endmodule

// File: doc/blockade_inputs.md
Name: blockade_inputs

Overview:
- Upstream neighbour of the Blockade core. Replaces the stubbed IN0/IN1/IN2 constants with real player controls, coin and DIP switches.
- Samples raw MiSTer buttons once per frame, debounces each bit, and latches the coin edge until the CPU acknowledges it via an OUT write.
- Presents an active-low port byte that the core's INP read mux consumes.
- Also drives a stretched coin-counter pulse.

Parameters:
- DEB_FRAMES, 2, consecutive identical frame samples required before a debounced bit changes (range 1..7).
- COIN_PULSE_FRAMES, 4, frames that coin_counter stays high after an accepted coin (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- vblank  in  1  core vblank level; a rising edge is the frame sample tick
- buttons  in  8  raw active-high: [3:0] P1 up/down/left/right, [7:4] P2 up/down/left/right
- coin  in  1  raw active-high coin switch
- start  in  1  raw active-high start
- dsw  in  8  DIP switches, static, not debounced
- port_sel  in  2  CPU ADDR[1:0] during INP
- outp_wr  in  1  one-clk strobe, CPU OUT cycle
- outp_data  in  8  CPU data on OUT
- data_out  out  8  port byte for the CPU read mux
- coin_counter  out  1  stretched coin meter pulse

Behaviour:
- Frame tick: tick = vblank & ~vblank_q, where vblank_q is registered. Exactly one tick per frame, 1 clk wide.
- Debounce (10 bits: buttons[7:0], coin, start):
  - Each bit has a registered stable value and a 3-bit counter.
  - On tick, if raw equals stable, the counter clears.
  - On tick, if raw differs from stable, the counter increments. When the incremented value reaches DEB_FRAMES, stable takes raw and the counter clears.
  - With no tick, nothing changes.
  - Latency: a raw change held for N frames changes stable on the DEB_FRAMES-th tick.
- Coin latch:
  - coin_edge = stable coin rising (stable_coin & ~stable_coin_q), evaluated on the clk where stable updates.
  - coin_edge sets coin_latch.
  - outp_wr with port_sel==2'd1 and outp_data[0]==1 clears coin_latch.
  - If set and clear occur in the same clk, set wins.
- Coin meter:
  - coin_edge loads a 4-bit counter with COIN_PULSE_FRAMES.
  - On each tick, the counter decrements if nonzero.
  - coin_counter = (counter != 0).
  - A new coin_edge while the counter is nonzero reloads it; there is no accumulation.
- Read mux (combinational from registered state, zero latency; the core samples it in the DBIN cycle):
  - port 0: {~coin_latch, ~start_stable, dsw[1:0], ~btn[3:0]}
  - port 1: {4'hF, ~btn[7:4]}
  - port 2: dsw
  - port 3: 8'hFF
- Reset values:
  - All stable bits 0, all counters 0, coin_latch 0, coin counter 0, vblank_q 1 (no spurious first tick).
  - data_out after reset: port0 = {1,1,dsw[1:0],4'hF}; port1 = 8'hFF.
  - coin_counter = 0.
- Reset mid-debounce or mid-pulse aborts the operation immediately; no pending state survives.
- outp_wr to ports 0, 2 or 3, or with outp_data[0]==0, has no effect.

Decomposition:
- Shared package blockade_pkg holds:
  - port index constants PORT_IN0..PORT_IN3 = 0..3
  - bit-position constants for the port 0 layout
  - COIN_ACK_BIT = 0
- One sub-module, blockade_debounce (per-bit stable register plus counter, parameter DEB_FRAMES, inputs clk/reset/tick/raw, output stable). It is instantiated 10 times via generate.

Test Plan:
- Reset, no inputs, dsw=8'h03:
  - port_sel=0 → data_out=8'hFF
  - port_sel=1 → 8'hFF
  - port_sel=2 → 8'h03
  - coin_counter=0
- buttons[0]=1 held for 1 tick then released → no change. Held for 2 ticks → port0 bit0 goes 0 exactly after the 2nd tick, and not before.
- coin held 3 ticks → port0 bit7=0 after the 2nd tick. coin_counter high for exactly 4 ticks, then low. Latch stays set after coin is released.
- Latch set, then outp_wr port 1 data 8'h01 → bit7 returns to 1 the next clk. outp_wr port 1 data 8'h00 → latch stays set.
- coin_edge and ack in the same clk → latch remains set. A second coin while coin_counter is nonzero reloads it to 4.
- Assert reset while a button is mid-debounce (counter=1) and coin_counter is active → all outputs return to reset values next clk. Button needs a full 2 ticks after reset to register.
